// File: rtl/c_accumulate.sv
// Multiply-accumulates streamed (a,b) pairs into ping-pong C banks and drains finished tiles; write 3 cycles after a beat, first output 2 cycles after the final write.
// Output holds on ready_C_in low; beats arriving while the target bank is still undrained are dropped and flagged. C_ACC_SATURATE_EN selects a saturating accumulate.
module c_accumulate #(
    parameter int D_WIDTH      = 64,
    parameter int ACC_WIDTH    = 128,
    parameter int A_PART_WIDTH = 1,
    parameter int B_NUM_WIDTH  = 1,
    parameter int K_WIDTH      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [D_WIDTH-1:0]   data_A_in,
    input  logic [D_WIDTH-1:0]   data_B_in,
    input  logic                 valid_AB_in,
    output logic [ACC_WIDTH-1:0] data_C_out,
    output logic                 valid_C_out,
    input  logic                 ready_C_in,
    output logic                 last_C_out,
    output logic                 err_overrun_out
);
    localparam int IW = A_PART_WIDTH + B_NUM_WIDTH;
    localparam int N  = 1 << IW;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_HOLD} state_t;

    generate
        if (N < 4) begin : g_bad_tile
            $error("c_accumulate: A_PART*B_NUM must be at least 4");
        end
        if (ACC_WIDTH < 2 * D_WIDTH) begin : g_bad_acc
            $error("c_accumulate: ACC_WIDTH must be at least 2*D_WIDTH");
        end
    endgenerate

    logic [ACC_WIDTH-1:0] r_mem [0:2*N-1];

    logic [IW-1:0]      r_idx;
    logic [K_WIDTH-1:0] r_kcnt;
    logic               r_acc_bank;
    logic [1:0]         r_full;
    logic               r_err;

    logic                       r_s1_vld;
    logic signed [D_WIDTH-1:0]  r_s1_a;
    logic signed [D_WIDTH-1:0]  r_s1_b;
    logic [IW:0]                r_s1_addr;
    logic                       r_s1_first;
    logic                       r_s1_last;

    logic                         r_s2_vld;
    logic signed [ACC_WIDTH-1:0]  r_s2_prod;
    logic signed [ACC_WIDTH-1:0]  r_s2_acc;
    logic [IW:0]                  r_s2_addr;
    logic                         r_s2_first;
    logic                         r_s2_last;

    state_t               r_state;
    logic                 r_drn_bank;
    logic [IW-1:0]        r_drn_ptr;
    logic [ACC_WIDTH-1:0] r_c_dat;
    logic                 r_c_vld;
    logic                 r_c_last;

    logic                          w_accept;
    logic                          w_drn_done;
    logic signed [2*D_WIDTH-1:0]   w_prod;
    logic signed [ACC_WIDTH-1:0]   w_sum;
    logic signed [ACC_WIDTH-1:0]   w_acc_nxt;
    logic [ACC_WIDTH-1:0]          w_wr_dat;

    // r_acc_bank flips when the tile's last beat is accepted, so beats of the next
    // tile are steered (and overrun-checked) against the bank they will really hit.
    assign w_accept   = valid_AB_in && !r_full[r_acc_bank];
    assign w_drn_done = (r_state == S_HOLD) && ready_C_in && r_c_last;
    assign w_prod     = r_s1_a * r_s1_b;
    assign w_sum      = r_s2_acc + r_s2_prod;

`ifdef C_ACC_SATURATE_EN
    logic w_ovf;
    assign w_ovf = (r_s2_acc[ACC_WIDTH-1] == r_s2_prod[ACC_WIDTH-1]) &&
                   (w_sum[ACC_WIDTH-1] != r_s2_acc[ACC_WIDTH-1]);
    always_comb begin
        w_acc_nxt = w_sum;
        if (w_ovf) begin
            w_acc_nxt = r_s2_acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                               : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_acc_nxt = w_sum;
`endif

    assign w_wr_dat = r_s2_first ? r_s2_prod : w_acc_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_kcnt     <= '0;
            r_acc_bank <= 1'b0;
            r_full     <= 2'b00;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idx <= r_idx + 1'b1;
                if (&r_idx) begin
                    r_kcnt <= r_kcnt + 1'b1;
                    if (&r_kcnt) begin
                        r_acc_bank <= ~r_acc_bank;
                    end
                end
            end
            if (valid_AB_in && !w_accept) begin
                r_err <= 1'b1;
            end
            if (w_drn_done) begin
                r_full[r_drn_bank] <= 1'b0;
            end
            if (r_s2_vld && r_s2_last) begin
                r_full[r_s2_addr[IW]] <= 1'b1;
            end
        end
    end

    // Same-address beats are >= 4 apart, so the S2 read always sees the prior write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_addr  <= '0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s2_vld   <= 1'b0;
            r_s2_prod  <= '0;
            r_s2_acc   <= '0;
            r_s2_addr  <= '0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_a     <= data_A_in;
                r_s1_b     <= data_B_in;
                r_s1_addr  <= {r_acc_bank, r_idx};
                r_s1_first <= (r_kcnt == '0);
                r_s1_last  <= (&r_kcnt) && (&r_idx);
            end
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_prod  <= ACC_WIDTH'(w_prod);
                r_s2_acc   <= r_mem[r_s1_addr];
                r_s2_addr  <= r_s1_addr;
                r_s2_first <= r_s1_first;
                r_s2_last  <= r_s1_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_s2_vld) begin
            r_mem[r_s2_addr] <= w_wr_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_drn_bank <= 1'b0;
            r_drn_ptr  <= '0;
            r_c_dat    <= '0;
            r_c_vld    <= 1'b0;
            r_c_last   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_full[r_drn_bank]) begin
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_c_dat  <= r_mem[{r_drn_bank, r_drn_ptr}];
                    r_c_vld  <= 1'b1;
                    r_c_last <= &r_drn_ptr;
                    r_state  <= S_HOLD;
                end
                S_HOLD: begin
                    if (ready_C_in) begin
                        r_c_vld  <= 1'b0;
                        r_c_last <= 1'b0;
                        if (r_c_last) begin
                            r_drn_ptr  <= '0;
                            r_drn_bank <= ~r_drn_bank;
                            r_state    <= S_IDLE;
                        end else begin
                            r_drn_ptr <= r_drn_ptr + 1'b1;
                            r_state   <= S_READ;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_C_out      = r_c_dat;
    assign valid_C_out     = r_c_vld;
    assign last_C_out      = r_c_last;
    assign err_overrun_out = r_err;
endmodule

// File: tb/tb_c_accumulate.sv
// Directed bench for c_accumulate with a 4-entry tile and two passes per tile.
module tb_c_accumulate;
    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  data_A_in;
    logic [63:0]  data_B_in;
    logic         valid_AB_in;
    logic [127:0] data_C_out;
    logic         valid_C_out;
    logic         ready_C_in;
    logic         last_C_out;
    logic         err_overrun_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] cap_d [16];
    logic         cap_l [16];
    int           cap_n;

    always #5 clk = ~clk;

    c_accumulate #(
        .D_WIDTH(64), .ACC_WIDTH(128), .A_PART_WIDTH(1), .B_NUM_WIDTH(1), .K_WIDTH(1)
    ) dut (
        .clk(clk), .rst(rst),
        .data_A_in(data_A_in), .data_B_in(data_B_in), .valid_AB_in(valid_AB_in),
        .data_C_out(data_C_out), .valid_C_out(valid_C_out), .ready_C_in(ready_C_in),
        .last_C_out(last_C_out), .err_overrun_out(err_overrun_out)
    );

    task automatic send_tile(input logic [63:0] a, input logic [63:0] b, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    valid_AB_in = 1'b0;
                    @(posedge clk); #1;
                end
            end
            data_A_in   = a;
            data_B_in   = b;
            valid_AB_in = 1'b1;
            @(posedge clk); #1;
        end
        valid_AB_in = 1'b0;
    endtask

    task automatic drain(input int n);
        cap_n      = 0;
        ready_C_in = 1'b1;
        for (int c = 0; c < 200 && cap_n < n; c++) begin
            if (valid_C_out) begin
                cap_d[cap_n] = data_C_out;
                cap_l[cap_n] = last_C_out;
                cap_n++;
            end
            @(posedge clk); #1;
        end
        ready_C_in = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; valid_AB_in = 1'b0; ready_C_in = 1'b0;
        data_A_in = '0; data_B_in = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (valid_C_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_C_out); end
        n_checks++; if (data_C_out !== 128'd0) begin n_fail++; $display("FAIL reset_data got %0h want 0", data_C_out); end
        n_checks++; if (last_C_out !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", last_C_out); end
        n_checks++; if (err_overrun_out !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_overrun_out); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int w;
        send_tile(64'd2, 64'd3, 1'b0);
        w = 0;
        while (!valid_C_out && w < 30) begin
            @(posedge clk); #1;
            w++;
        end
        n_checks++; if (w !== 4) begin n_fail++; $display("FAIL basic_latency got %0d cycles want 4", w); end
        drain(4);
        n_checks++; if (cap_n !== 4) begin n_fail++; $display("FAIL basic_count got %0d want 4", cap_n); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cap_d[i] !== 128'd12 || cap_l[i] !== (i == 3)) begin
                n_fail++; $display("FAIL basic_entry%0d got %0d/%b want 12/%b", i, cap_d[i], cap_l[i], i == 3);
            end
        end
    endtask

    task automatic test_signed;
        logic [127:0] exp;
        exp = -128'sd70;
        for (int g = 0; g < 2; g++) begin
            send_tile(-64'sd5, 64'sd7, g == 1);
            drain(4);
            n_checks++; if (cap_n !== 4) begin n_fail++; $display("FAIL signed_count g%0d got %0d want 4", g, cap_n); end
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (cap_d[i] !== exp || cap_l[i] !== (i == 3)) begin
                    n_fail++; $display("FAIL signed_g%0d_entry%0d got %0h/%b want %0h/%b", g, i, cap_d[i], cap_l[i], exp, i == 3);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] hold_d;
        logic         hold_l;
        bit           stable;
        ready_C_in = 1'b0;
        send_tile(64'd1, 64'd1, 1'b0);
        send_tile(64'd3, 64'd4, 1'b0);
        for (int c = 0; c < 50 && !valid_C_out; c++) begin
            @(posedge clk); #1;
        end
        n_checks++; if (valid_C_out !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b want 1", valid_C_out); end
        hold_d = data_C_out;
        hold_l = last_C_out;
        stable = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (data_C_out !== hold_d || last_C_out !== hold_l || valid_C_out !== 1'b1) stable = 1'b0;
        end
        n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL b2b_hold got unstable want stable"); end
        n_checks++; if (hold_d !== 128'd2) begin n_fail++; $display("FAIL b2b_held_data got %0d want 2", hold_d); end
        drain(8);
        n_checks++; if (cap_n !== 8) begin n_fail++; $display("FAIL b2b_count got %0d want 8", cap_n); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (cap_d[i] !== ((i < 4) ? 128'd2 : 128'd24) || cap_l[i] !== (i == 3 || i == 7)) begin
                n_fail++; $display("FAIL b2b_entry%0d got %0d/%b want %0d/%b", i, cap_d[i], cap_l[i], (i < 4) ? 2 : 24, i == 3 || i == 7);
            end
        end
        n_checks++; if (err_overrun_out !== 1'b0) begin n_fail++; $display("FAIL b2b_err got %b want 0", err_overrun_out); end
    endtask

    task automatic test_overrun;
        int extra;
        ready_C_in = 1'b0;
        send_tile(64'd1, 64'd2, 1'b0);
        send_tile(64'd2, 64'd2, 1'b0);
        n_checks++; if (err_overrun_out !== 1'b0) begin n_fail++; $display("FAIL ovr_err_before got %b want 0", err_overrun_out); end
        send_tile(64'd5, 64'd5, 1'b0);
        n_checks++; if (err_overrun_out !== 1'b1) begin n_fail++; $display("FAIL ovr_err_set got %b want 1", err_overrun_out); end
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (err_overrun_out !== 1'b1) begin n_fail++; $display("FAIL ovr_err_sticky got %b want 1", err_overrun_out); end
        drain(8);
        n_checks++; if (cap_n !== 8) begin n_fail++; $display("FAIL ovr_count got %0d want 8", cap_n); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (cap_d[i] !== ((i < 4) ? 128'd4 : 128'd8) || cap_l[i] !== (i == 3 || i == 7)) begin
                n_fail++; $display("FAIL ovr_entry%0d got %0d/%b want %0d/%b", i, cap_d[i], cap_l[i], (i < 4) ? 4 : 8, i == 3 || i == 7);
            end
        end
        extra = 0;
        ready_C_in = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (valid_C_out) extra++;
        end
        ready_C_in = 1'b0;
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ovr_dropped got %0d extra outputs want 0", extra); end
        n_checks++; if (err_overrun_out !== 1'b1) begin n_fail++; $display("FAIL ovr_err_end got %b want 1", err_overrun_out); end
    endtask

    task automatic test_wrap;
        logic [127:0] exp;
`ifdef C_ACC_SATURATE_EN
        exp = 128'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff;
`else
        exp = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
`endif
        send_tile(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        drain(4);
        n_checks++; if (cap_n !== 4) begin n_fail++; $display("FAIL wrap_count got %0d want 4", cap_n); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cap_d[i] !== exp) begin n_fail++; $display("FAIL wrap_entry%0d got %0h want %0h", i, cap_d[i], exp); end
        end
    endtask

    task automatic test_reset_mid_drain;
        ready_C_in = 1'b0;
        send_tile(64'd1, 64'd1, 1'b0);
        for (int c = 0; c < 50 && !valid_C_out; c++) begin
            @(posedge clk); #1;
        end
        n_checks++; if (valid_C_out !== 1'b1) begin n_fail++; $display("FAIL mid_valid got %b want 1", valid_C_out); end
        rst = 1'b1;
        #2;
        n_checks++; if (valid_C_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", valid_C_out); end
        n_checks++; if (data_C_out !== 128'd0) begin n_fail++; $display("FAIL mid_rst_data got %0h want 0", data_C_out); end
        n_checks++; if (err_overrun_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err got %b want 0", err_overrun_out); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_tile(64'd3, 64'd3, 1'b0);
        drain(4);
        n_checks++; if (cap_n !== 4) begin n_fail++; $display("FAIL mid_count got %0d want 4", cap_n); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cap_d[i] !== 128'd18 || cap_l[i] !== (i == 3)) begin
                n_fail++; $display("FAIL mid_entry%0d got %0d/%b want 18/%b", i, cap_d[i], cap_l[i], i == 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_back_to_back();
        test_overrun();
        test_wrap();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before the test sequence completed");
        $fatal(1);
    end
endmodule
